// File: rtl/pito_pkg.sv
// Shared types and constants for the pito instruction-memory loader.
package pito_pkg;

  typedef enum logic [2:0] {
    LD_IDLE = 3'd0,
    LD_HDR  = 3'd1,
    LD_DATA = 3'd2,
    LD_CSUM = 3'd3,
    LD_DONE = 3'd4,
    LD_ERR  = 3'd5
  } loader_state_t;

  localparam int unsigned LOADER_HDR_BYTES  = 4;
  localparam int unsigned LOADER_CSUM_BYTES = 4;
  localparam int unsigned LOADER_BYTE_CNT_W = 2;

  // States in which the loader consumes stream bytes.
  function automatic logic is_stream_state(input loader_state_t s);
    return (s == LD_HDR) || (s == LD_DATA) || (s == LD_CSUM);
  endfunction

endpackage

// File: rtl/pito_byte_packer.sv
// Little-endian 8->32 packer; the word is presented combinationally on the cycle of its 4th byte.
module pito_byte_packer
  import pito_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clear,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word_c,
  output logic        o_word_valid_c
);

  localparam logic [LOADER_BYTE_CNT_W-1:0] LAST_IDX = LOADER_BYTE_CNT_W'(LOADER_HDR_BYTES - 1);

  logic [LOADER_BYTE_CNT_W-1:0] r_cnt;
  logic [23:0]                  r_low;

  // Bytes shift in from the top so byte0 ends up in bits [7:0] after three bytes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_low <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
      r_low <= '0;
    end else if (i_byte_valid) begin
      r_cnt <= r_cnt + LOADER_BYTE_CNT_W'(1);
      r_low <= {i_byte, r_low[23:8]};
    end
  end

  assign o_word_c       = {i_byte, r_low};
  assign o_word_valid_c = i_byte_valid & ~i_clear & (r_cnt == LAST_IDX);

endmodule

// File: rtl/pito_imem_loader.sv
// Host byte-stream program loader driving the pito imem write port and program-mode line.
// Optional trailing checksum check enabled by defining PITO_LOADER_CSUM_EN.
module pito_imem_loader
  import pito_pkg::*;
#(
  parameter int unsigned IMEM_ADDR_W = 10,
  parameter int unsigned DATA_W      = 32
) (
  input  logic                   pito_io_clk,
  input  logic                   pito_io_rst_n,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [7:0]             s_data_i,
  input  logic                   s_valid_i,
  output logic                   s_ready_o,
  output logic [IMEM_ADDR_W-1:0] imem_addr_o,
  output logic [DATA_W-1:0]      imem_data_o,
  output logic                   imem_w_en_o,
  output logic                   pito_program_o,
  output logic                   load_done_o,
  output logic                   load_err_o
);

  localparam int unsigned CNT_W     = IMEM_ADDR_W + 1;
  localparam logic [31:0] CAP_WORDS = 32'(64'(1) << IMEM_ADDR_W);

`ifdef PITO_LOADER_CSUM_EN
  localparam loader_state_t ST_END = LD_CSUM;
`else
  localparam loader_state_t ST_END = LD_DONE;
`endif

  if (DATA_W != 32) begin : g_data_w_chk
    $error("pito_imem_loader: DATA_W must be 32");
  end

  loader_state_t    r_state;
  loader_state_t    w_state_nxt;
  logic [CNT_W-1:0] r_n;
  logic [CNT_W-1:0] r_wcnt;
  logic [CNT_W-1:0] w_wcnt_nxt;
  logic [31:0]      w_word;
  logic             w_word_valid;
  logic             w_hs;
  logic             w_start;
  logic             w_clear;
  logic             w_write;
`ifdef PITO_LOADER_CSUM_EN
  logic [31:0]      r_csum;
`endif

  assign w_hs       = s_valid_i & s_ready_o & ~abort_i;
  assign w_start    = start_i & ~abort_i &
                      ((r_state == LD_IDLE) || (r_state == LD_DONE) || (r_state == LD_ERR));
  assign w_clear    = abort_i | w_start;
  assign w_wcnt_nxt = r_wcnt + CNT_W'(1);
  assign w_write    = w_word_valid & (r_state == LD_DATA);

  pito_byte_packer u_packer (
    .i_clk          (pito_io_clk),
    .i_rst_n        (pito_io_rst_n),
    .i_clear        (w_clear),
    .i_byte_valid   (w_hs),
    .i_byte         (s_data_i),
    .o_word_c       (w_word),
    .o_word_valid_c (w_word_valid)
  );

  // Next-state decode; abort has priority over everything, including a same-cycle start.
  always_comb begin
    w_state_nxt = r_state;
    if (abort_i) begin
      w_state_nxt = LD_IDLE;
    end else if (w_start) begin
      w_state_nxt = LD_HDR;
    end else if (w_word_valid) begin
      case (r_state)
        LD_HDR: begin
          if (w_word == 32'd0)           w_state_nxt = ST_END;
          else if (w_word > CAP_WORDS)   w_state_nxt = LD_ERR;
          else                           w_state_nxt = LD_DATA;
        end
        LD_DATA: begin
          if (w_wcnt_nxt == r_n) w_state_nxt = ST_END;
        end
`ifdef PITO_LOADER_CSUM_EN
        LD_CSUM: begin
          w_state_nxt = (w_word == r_csum) ? LD_DONE : LD_ERR;
        end
`endif
        default: ;
      endcase
    end
  end

  // State and registered outputs; program stays high through the cycle of the last strobe.
  always_ff @(posedge pito_io_clk or negedge pito_io_rst_n) begin
    if (!pito_io_rst_n) begin
      r_state        <= LD_IDLE;
      r_n            <= '0;
      r_wcnt         <= '0;
      s_ready_o      <= 1'b0;
      imem_addr_o    <= '0;
      imem_data_o    <= '0;
      imem_w_en_o    <= 1'b0;
      pito_program_o <= 1'b0;
      load_done_o    <= 1'b0;
      load_err_o     <= 1'b0;
`ifdef PITO_LOADER_CSUM_EN
      r_csum         <= '0;
`endif
    end else begin
      r_state        <= w_state_nxt;
      s_ready_o      <= is_stream_state(w_state_nxt);
      pito_program_o <= is_stream_state(w_state_nxt) | w_write;
      imem_w_en_o    <= w_write;

      if (w_start) begin
        r_wcnt      <= '0;
        imem_addr_o <= '0;
        load_done_o <= 1'b0;
        load_err_o  <= 1'b0;
`ifdef PITO_LOADER_CSUM_EN
        r_csum      <= '0;
`endif
      end else begin
        if ((w_state_nxt == LD_DONE) && (r_state != LD_DONE)) load_done_o <= 1'b1;
        if ((w_state_nxt == LD_ERR) && (r_state != LD_ERR))   load_err_o  <= 1'b1;
      end

      if (w_word_valid && (r_state == LD_HDR)) r_n <= CNT_W'(w_word);

      if (w_write) begin
        imem_addr_o <= r_wcnt[IMEM_ADDR_W-1:0];
        imem_data_o <= w_word;
        r_wcnt      <= w_wcnt_nxt;
`ifdef PITO_LOADER_CSUM_EN
        r_csum      <= r_csum + w_word;
`endif
      end
    end
  end

endmodule

// File: tb/tb_pito_imem_loader.sv
// Directed/randomized bench for pito_imem_loader with a queue-based write reference model.
module tb_pito_imem_loader;

  localparam int unsigned AW  = 4;
  localparam int unsigned CAP = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic [7:0]    s_data_i = 8'h00;
  logic          s_valid_i = 1'b0;
  logic          s_ready_o;
  logic [AW-1:0] imem_addr_o;
  logic [31:0]   imem_data_o;
  logic          imem_w_en_o;
  logic          pito_program_o;
  logic          load_done_o;
  logic          load_err_o;

  int checks = 0;
  int errors = 0;
  int prog_bad = 0;
  logic [31:0] act_addr[$];
  logic [31:0] act_data[$];
  logic [31:0] wbuf[0:31];

  pito_imem_loader #(.IMEM_ADDR_W(AW), .DATA_W(32)) dut (
    .pito_io_clk   (clk),
    .pito_io_rst_n (rst_n),
    .start_i       (start_i),
    .abort_i       (abort_i),
    .s_data_i      (s_data_i),
    .s_valid_i     (s_valid_i),
    .s_ready_o     (s_ready_o),
    .imem_addr_o   (imem_addr_o),
    .imem_data_o   (imem_data_o),
    .imem_w_en_o   (imem_w_en_o),
    .pito_program_o(pito_program_o),
    .load_done_o   (load_done_o),
    .load_err_o    (load_err_o)
  );

  always #5 clk = ~clk;

  // Record every imem write as seen by the core.
  always @(posedge clk) begin
    if (rst_n && imem_w_en_o) begin
      act_addr.push_back(32'(imem_addr_o));
      act_data.push_back(imem_data_o);
      if (!pito_program_o) prog_bad++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    s_data_i  = b;
    s_valid_i = 1'b1;
    chk("s_ready_when_sending", 32'(s_ready_o), 32'd1);
    @(negedge clk);
    s_valid_i = 1'b0;
    s_data_i  = 8'($urandom());
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gaps);
  endtask

  task automatic do_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag, input bit exp_done, input bit exp_err);
    chk({tag, "_done"},    32'(load_done_o),    32'(exp_done));
    chk({tag, "_err"},     32'(load_err_o),     32'(exp_err));
    chk({tag, "_ready"},   32'(s_ready_o),      32'd0);
    chk({tag, "_program"}, 32'(pito_program_o), 32'd0);
  endtask

  // Full load of n header words from wbuf; expectations come from simple list rules.
  task automatic run_load(input string tag, input logic [31:0] n, input bit gaps, input bit bad_csum);
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] sum;
    bit          ok_len;
    bit          exp_done;
    bit          exp_err;
    act_addr.delete();
    act_data.delete();
    prog_bad = 0;
    sum      = 32'd0;
    ok_len   = (n <= 32'(CAP));
    if (ok_len) begin
      for (int i = 0; i < int'(n); i++) begin
        exp_addr.push_back(32'(i));
        exp_data.push_back(wbuf[i]);
        sum = sum + wbuf[i];
      end
    end
    do_start();
    chk({tag, "_program_after_start"}, 32'(pito_program_o), 32'd1);
    send_word(n, gaps);
    if (ok_len) begin
      for (int i = 0; i < int'(n); i++) begin
        if (i == 1) do_start();
        send_word(wbuf[i], gaps);
      end
`ifdef PITO_LOADER_CSUM_EN
      send_word(bad_csum ? sum + 32'd1 : sum, gaps);
`endif
    end
    repeat (3) @(negedge clk);
    exp_err  = !ok_len;
    exp_done = ok_len;
`ifdef PITO_LOADER_CSUM_EN
    if (ok_len && bad_csum) begin
      exp_err  = 1'b1;
      exp_done = 1'b0;
    end
`endif
    check_idle_outputs(tag, exp_done, exp_err);
    chk({tag, "_nwrites"}, 32'(act_addr.size()), 32'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < act_addr.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), act_addr[i], exp_addr[i]);
      chk($sformatf("%s_data%0d", tag, i), act_data[i], exp_data[i]);
    end
    chk({tag, "_program_during_writes"}, 32'(prog_bad), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) wbuf[i] = $urandom();

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_ready",   32'(s_ready_o),      32'd0);
    chk("rst_wen",     32'(imem_w_en_o),    32'd0);
    chk("rst_program", 32'(pito_program_o), 32'd0);
    chk("rst_done",    32'(load_done_o),    32'd0);
    chk("rst_err",     32'(load_err_o),     32'd0);
    chk("rst_addr",    32'(imem_addr_o),    32'd0);
    chk("rst_data",    imem_data_o,         32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Known program
    wbuf[0] = 32'h0000_0013;
    wbuf[1] = 32'h0010_0093;
    wbuf[2] = 32'hDEAD_BEEF;
    run_load("n3", 32'd3, 1'b0, 1'b0);

    run_load("n0", 32'd0, 1'b0, 1'b0);
    run_load("over_cap", 32'(CAP + 1), 1'b0, 1'b0);

    for (int i = 0; i < 32; i++) wbuf[i] = $urandom();
    run_load("full_cap", 32'(CAP), 1'b0, 1'b0);

    // Abort with one full word and two bytes of the second accepted
    act_addr.delete();
    act_data.delete();
    do_start();
    send_word(32'd2, 1'b0);
    send_word(wbuf[0], 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    abort_i   = 1'b1;
    s_valid_i = 1'b1;
    s_data_i  = 8'hCC;
    @(negedge clk);
    abort_i   = 1'b0;
    s_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("abort", 1'b0, 1'b0);
    chk("abort_nwrites", 32'(act_addr.size()), 32'd1);
    if (act_addr.size() > 0) begin
      chk("abort_addr0", act_addr[0], 32'd0);
      chk("abort_data0", act_data[0], wbuf[0]);
    end

    // Partial word from the aborted load must not leak into the next one
    wbuf[0] = $urandom();
    run_load("after_abort", 32'd1, 1'b0, 1'b0);

    // Same words, gap-free and with random valid gaps
    for (int i = 0; i < 8; i++) wbuf[i] = $urandom();
    run_load("n8_nogap", 32'd8, 1'b0, 1'b0);
    run_load("n8_gaps", 32'd8, 1'b1, 1'b0);

`ifdef PITO_LOADER_CSUM_EN
    run_load("csum_bad", 32'd5, 1'b0, 1'b1);
`endif

    // Start and abort in the same cycle: abort wins
    start_i = 1'b1;
    abort_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    abort_i = 1'b0;
    @(negedge clk);
    chk("start_abort_ready",   32'(s_ready_o),      32'd0);
    chk("start_abort_program", 32'(pito_program_o), 32'd0);

    // Reset mid-load clears outputs immediately
    do_start();
    send_word(32'd4, 1'b0);
    send_byte(8'h11, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready",   32'(s_ready_o),      32'd0);
    chk("midrst_program", 32'(pito_program_o), 32'd0);
    chk("midrst_addr",    32'(imem_addr_o),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 32; i++) wbuf[i] = $urandom();
    run_load("after_rst", 32'd2, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
